// File: rtl/handshake_arbiter.sv
// ---------------------------------------------------------------------------
// handshake_arbiter
//
// Clocked N-way arbiter for four-phase req/ack handshakes. Several client
// request channels share one upstream request channel. Each client keeps its
// request high until it sees its acknowledge. The arbiter then carries the
// full four-phase exchange through to the upstream side before it considers
// another client.
//
// Parameters:
//   N           number of client channels (2..32)
//   RR          1 = round-robin selection, 0 = fixed priority (lowest wins)
//   SYNC_STAGES synchroniser flops on req_in and ack_up (0..3, 0 = direct)
//   IDX_W       width of the grant index
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset, release synchronised inside
//   req_in     client requests, one bit per client
//   ack_out    client acknowledges, one-hot or zero
//   req_up     upstream request
//   ack_up     upstream acknowledge
//   gnt_valid  high while a client owns the upstream channel
//   gnt_idx    index of the owning client (holds last owner when idle)
// ---------------------------------------------------------------------------
module handshake_arbiter #(
  parameter int N           = 4,
  parameter int RR          = 1,
  parameter int SYNC_STAGES = 2,
  parameter int IDX_W       = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req_in,
  output logic [N-1:0]     ack_out,
  output logic             req_up,
  input  logic             ack_up,
  output logic             gnt_valid,
  output logic [IDX_W-1:0] gnt_idx
);

  typedef enum logic [1:0] {IDLE, GRANT, HOLD, RELEASE} state_t;

  state_t           state, state_n;
  logic [1:0]       rst_sync;
  logic             rst_int_n;
  logic [N-1:0]     req_s;
  logic             ack_s;
  logic [IDX_W-1:0] ptr, ptr_n;
  logic [IDX_W-1:0] winner;
  logic [N-1:0]     ack_out_n;
  logic             req_up_n;
  logic             gnt_valid_n;
  logic [IDX_W-1:0] gnt_idx_n;

  // Reset synchroniser. Assertion reaches the whole design at once, so a
  // reset mid-transaction drops every output immediately. Release passes
  // through two flops, so no flop leaves reset close to a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync <= 2'b00;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end

  assign rst_int_n = rst_sync[1];

  // Input synchronisers. Clients and the upstream partner may be
  // asynchronous to clk. Every decision below uses only the synchronised
  // copies, so a metastable sample never reaches the state machine. With
  // zero stages the raw inputs feed the logic directly.
  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign req_s = req_in;
      assign ack_s = ack_up;
    end else begin : g_sync
      logic [N-1:0] req_pipe [SYNC_STAGES];
      logic         ack_pipe [SYNC_STAGES];

      always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
          for (int i = 0; i < SYNC_STAGES; i++) begin
            req_pipe[i] <= '0;
            ack_pipe[i] <= 1'b0;
          end
        end else begin
          req_pipe[0] <= req_in;
          ack_pipe[0] <= ack_up;
          for (int i = 1; i < SYNC_STAGES; i++) begin
            req_pipe[i] <= req_pipe[i-1];
            ack_pipe[i] <= ack_pipe[i-1];
          end
        end
      end

      assign req_s = req_pipe[SYNC_STAGES-1];
      assign ack_s = ack_pipe[SYNC_STAGES-1];
    end
  endgenerate

  // Winner selection. Round-robin starts the cyclic search one past the
  // previous winner, so every waiting client is served within N grants.
  // Fixed priority always starts at index 0, so the lowest index wins.
  always_comb begin
    int               base;
    int               cand;
    logic [IDX_W-1:0] cand_idx;
    logic             found;
    winner   = '0;
    found    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    base     = (RR != 0) ? int'(ptr) + 1 : 0;
    for (int k = 0; k < N; k++) begin
      cand     = (base + k) % N;
      cand_idx = IDX_W'(cand);
      if (!found && req_s[cand_idx]) begin
        found  = 1'b1;
        winner = cand_idx;
      end
    end
  end

  // Next-state and next-output logic. All outputs are computed here one
  // cycle ahead and then registered, so no output is driven through logic.
  // Requests from clients other than the owner are ignored until IDLE.
  // This is safe because clients hold their requests until acknowledged.
  // A client that drops its request before the upstream ack arrives never
  // sees an ack. The machine releases the upstream channel instead.
  always_comb begin
    state_n     = state;
    ptr_n       = ptr;
    ack_out_n   = ack_out;
    req_up_n    = req_up;
    gnt_valid_n = gnt_valid;
    gnt_idx_n   = gnt_idx;
    unique case (state)
      IDLE: begin
        if (|req_s) begin
          state_n     = GRANT;
          req_up_n    = 1'b1;
          gnt_valid_n = 1'b1;
          gnt_idx_n   = winner;
          if (RR != 0) begin
            ptr_n = winner;
          end
        end
      end
      GRANT: begin
        if (ack_s) begin
          if (req_s[gnt_idx]) begin
            ack_out_n          = '0;
            ack_out_n[gnt_idx] = 1'b1;
            state_n            = HOLD;
          end else begin
            req_up_n = 1'b0;
            state_n  = RELEASE;
          end
        end
      end
      HOLD: begin
        if (!req_s[gnt_idx]) begin
          ack_out_n = '0;
          req_up_n  = 1'b0;
          state_n   = RELEASE;
        end
      end
      RELEASE: begin
        if (!ack_s) begin
          gnt_valid_n = 1'b0;
          state_n     = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State and output registers. The pointer resets to N-1, so the first
  // round-robin search after reset begins with client 0.
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state     <= IDLE;
      ptr       <= IDX_W'(N - 1);
      ack_out   <= '0;
      req_up    <= 1'b0;
      gnt_valid <= 1'b0;
      gnt_idx   <= '0;
    end else begin
      state     <= state_n;
      ptr       <= ptr_n;
      ack_out   <= ack_out_n;
      req_up    <= req_up_n;
      gnt_valid <= gnt_valid_n;
      gnt_idx   <= gnt_idx_n;
    end
  end

endmodule

// File: tb/tb_handshake_arbiter.sv
// ---------------------------------------------------------------------------
// tb_handshake_arbiter
//
// Directed bench for handshake_arbiter using three instances:
//   dut_rr  N=4, round-robin, two synchroniser stages (manual or auto partners)
//   dut_fp  N=4, fixed priority, two synchroniser stages (auto partners)
//   dut_s0  N=4, round-robin, no synchronisers (zero-delay partners)
// Auto partners: each client drops its request as soon as it sees its ack,
// and the upstream side acks exactly while req_up is high.
// ---------------------------------------------------------------------------
module tb_handshake_arbiter;

  logic       clk;
  logic       rst_n;

  logic       auto_rr;
  logic [3:0] want_rr;
  logic [3:0] req_drv;
  logic       ack_drv;
  logic [3:0] req_rr;
  logic       ack_up_rr;
  logic [3:0] ack_out_rr;
  logic       req_up_rr;
  logic       gnt_valid_rr;
  logic [1:0] gnt_idx_rr;

  logic [3:0] want_fp;
  logic [3:0] req_fp;
  logic       ack_up_fp;
  logic [3:0] ack_out_fp;
  logic       req_up_fp;
  logic       gnt_valid_fp;
  logic [1:0] gnt_idx_fp;

  logic [3:0] want_s0;
  logic [3:0] req_s0;
  logic       ack_up_s0;
  logic [3:0] ack_out_s0;
  logic       req_up_s0;
  logic       gnt_valid_s0;
  logic [1:0] gnt_idx_s0;

  int         checks;
  int         failures;
  int         got;
  int         last;
  logic       prev;
  logic       prev_req;
  logic       prev_ack;

  // Partner models. Clients withdraw a request as soon as they see their
  // ack. The upstream side mirrors req_up back as its ack with no delay.
  assign req_rr    = auto_rr ? (want_rr & ~ack_out_rr) : req_drv;
  assign ack_up_rr = auto_rr ? req_up_rr : ack_drv;
  assign req_fp    = want_fp & ~ack_out_fp;
  assign ack_up_fp = req_up_fp;
  assign req_s0    = want_s0 & ~ack_out_s0;
  assign ack_up_s0 = req_up_s0;

  handshake_arbiter #(.N(4), .RR(1), .SYNC_STAGES(2)) dut_rr (
    .clk(clk), .rst_n(rst_n), .req_in(req_rr), .ack_out(ack_out_rr),
    .req_up(req_up_rr), .ack_up(ack_up_rr), .gnt_valid(gnt_valid_rr),
    .gnt_idx(gnt_idx_rr)
  );

  handshake_arbiter #(.N(4), .RR(0), .SYNC_STAGES(2)) dut_fp (
    .clk(clk), .rst_n(rst_n), .req_in(req_fp), .ack_out(ack_out_fp),
    .req_up(req_up_fp), .ack_up(ack_up_fp), .gnt_valid(gnt_valid_fp),
    .gnt_idx(gnt_idx_fp)
  );

  handshake_arbiter #(.N(4), .RR(1), .SYNC_STAGES(0)) dut_s0 (
    .clk(clk), .rst_n(rst_n), .req_in(req_s0), .ack_out(ack_out_s0),
    .req_up(req_up_s0), .ack_up(ack_up_s0), .gnt_valid(gnt_valid_s0),
    .gnt_idx(gnt_idx_s0)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog so the run always ends even if the design hangs.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired actual=running required=finished");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] req, input logic ack, input int n);
    req_drv = req;
    ack_drv = ack;
    tick(n);
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(4);
  endtask

  // Directed test sequence.
  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    auto_rr  = 1'b0;
    want_rr  = 4'b0000;
    req_drv  = 4'b0000;
    ack_drv  = 1'b0;
    want_fp  = 4'b0000;
    want_s0  = 4'b0000;

    tick(3);
    checkOutput("rst_req_up", 32'(req_up_rr), 0);
    checkOutput("rst_ack_out", 32'(ack_out_rr), 0);
    checkOutput("rst_gnt_valid", 32'(gnt_valid_rr), 0);
    checkOutput("rst_gnt_idx", 32'(gnt_idx_rr), 0);
    rst_n = 1'b1;
    tick(4);
    checkOutput("post_rst_idle", 32'(gnt_valid_rr), 0);

    applyStimulus(4'b0100, 1'b0, 2);
    checkOutput("single_req_up_early", 32'(req_up_rr), 0);
    tick(1);
    checkOutput("single_req_up", 32'(req_up_rr), 1);
    checkOutput("single_gnt_idx", 32'(gnt_idx_rr), 2);
    checkOutput("single_gnt_valid", 32'(gnt_valid_rr), 1);
    applyStimulus(4'b0100, 1'b1, 2);
    checkOutput("single_ack_early", 32'(ack_out_rr), 0);
    tick(1);
    checkOutput("single_ack_out", 32'(ack_out_rr), 4);
    applyStimulus(4'b0000, 1'b1, 2);
    checkOutput("single_hold_ack", 32'(ack_out_rr), 4);
    checkOutput("single_hold_req_up", 32'(req_up_rr), 1);
    tick(1);
    checkOutput("single_fall_ack", 32'(ack_out_rr), 0);
    checkOutput("single_fall_req_up", 32'(req_up_rr), 0);
    checkOutput("single_release_valid", 32'(gnt_valid_rr), 1);
    applyStimulus(4'b0000, 1'b0, 2);
    checkOutput("single_release_hold", 32'(gnt_valid_rr), 1);
    tick(1);
    checkOutput("single_idle", 32'(gnt_valid_rr), 0);
    checkOutput("single_idx_held", 32'(gnt_idx_rr), 2);

    doReset();
    want_rr = 4'b1111;
    auto_rr = 1'b1;
    got  = 0;
    prev = 1'b0;
    for (int c = 0; c < 300 && got < 6; c++) begin
      tick(1);
      if (gnt_valid_rr && !prev) begin
        checkOutput("rr_order", 32'(gnt_idx_rr), got % 4);
        got++;
      end
      prev = gnt_valid_rr;
    end
    checkOutput("rr_count", got, 6);
    want_rr = 4'b0000;
    tick(30);
    auto_rr = 1'b0;

    doReset();
    applyStimulus(4'b0001, 1'b0, 3);
    checkOutput("wd_grant", 32'(gnt_valid_rr), 1);
    checkOutput("wd_idx", 32'(gnt_idx_rr), 0);
    req_drv = 4'b0000;
    ack_drv = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick(1);
      checkOutput("wd_no_ack", 32'(ack_out_rr), 0);
    end
    checkOutput("wd_release_req_up", 32'(req_up_rr), 0);
    checkOutput("wd_release_valid", 32'(gnt_valid_rr), 1);
    ack_drv = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick(1);
      checkOutput("wd_no_ack_late", 32'(ack_out_rr), 0);
    end
    checkOutput("wd_idle", 32'(gnt_valid_rr), 0);

    doReset();
    applyStimulus(4'b0011, 1'b0, 3);
    checkOutput("mid_rst_first_idx", 32'(gnt_idx_rr), 0);
    applyStimulus(4'b0011, 1'b1, 3);
    checkOutput("mid_rst_hold_ack", 32'(ack_out_rr), 1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_req_up", 32'(req_up_rr), 0);
    checkOutput("mid_rst_ack_out", 32'(ack_out_rr), 0);
    checkOutput("mid_rst_gnt_valid", 32'(gnt_valid_rr), 0);
    ack_drv = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(7);
    checkOutput("mid_rst_regrant_valid", 32'(gnt_valid_rr), 1);
    checkOutput("mid_rst_regrant_idx", 32'(gnt_idx_rr), 0);
    req_drv = 4'b0000;

    doReset();
    want_fp = 4'b1010;
    got  = 0;
    prev = 1'b0;
    for (int c = 0; c < 300 && got < 4; c++) begin
      tick(1);
      if (gnt_valid_fp && !prev) begin
        if (got < 3) begin
          checkOutput("fp_idx", 32'(gnt_idx_fp), 1);
        end else begin
          checkOutput("fp_after_drop", 32'(gnt_idx_fp), 3);
        end
        got++;
        if (got == 3) begin
          want_fp = 4'b1000;
        end
      end
      prev = gnt_valid_fp;
    end
    checkOutput("fp_count", got, 4);
    want_fp = 4'b0000;
    tick(30);

    doReset();
    want_s0  = 4'b1111;
    got      = 0;
    last     = 0;
    prev     = 1'b0;
    prev_req = 1'b0;
    prev_ack = 1'b0;
    for (int c = 0; c < 80 && got < 6; c++) begin
      tick(1);
      checkOutput("s0_onehot", 32'($onehot0(ack_out_s0)), 1);
      checkOutput("s0_rise_under_ack", 32'(!prev_req && req_up_s0 && prev_ack), 0);
      if (gnt_valid_s0 && !prev) begin
        checkOutput("s0_order", 32'(gnt_idx_s0), got % 4);
        if (got > 0) begin
          checkOutput("s0_period", c - last, 4);
        end
        last = c;
        got++;
      end
      prev     = gnt_valid_s0;
      prev_req = req_up_s0;
      prev_ack = ack_up_s0;
    end
    checkOutput("s0_count", got, 6);
    want_s0 = 4'b0000;
    tick(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
